// File: rtl/mem_channel_responder_if.sv
// mem_channel_responder_if: per-channel read/write request bus between the arbitration controller and the memory responder
//   master: the controller side; drives valid/address/write data and observes ready and read data
//   slave : the responder side; observes requests and drives ready and read data
interface mem_channel_responder_if #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4
);
    logic [NUM_CHANNELS-1:0]                mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_read_address;
    logic [NUM_CHANNELS-1:0]                mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_read_data;
    logic [NUM_CHANNELS-1:0]                mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0] mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] mem_write_data;
    logic [NUM_CHANNELS-1:0]                mem_write_ready;

    modport master (
        output mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready
    );

    modport slave (
        input  mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready
    );
endinterface

// File: rtl/mem_channel_responder.sv
// mem_channel_responder: multi-channel fixed-latency memory responder over a flop-based store
//   clk              rising-edge clock
//   reset            asynchronous active-low reset; clears engines, read data and the store
//   bus (slave)      per-channel read/write valid, address, write data in; ready and read data out
//   perf_read_count  saturating count of completed reads   (only with MEM_RESP_PERF_EN)
//   perf_write_count saturating count of completed writes  (only with MEM_RESP_PERF_EN)
module mem_channel_responder #(
    parameter int ADDR_BITS    = 8,
    parameter int DATA_BITS    = 8,
    parameter int NUM_CHANNELS = 4,
    parameter int LATENCY      = 2
) (
    input  logic clk,
    input  logic reset,
    mem_channel_responder_if.slave bus
`ifdef MEM_RESP_PERF_EN
    ,
    output logic [15:0] perf_read_count,
    output logic [15:0] perf_write_count
`endif
);
    localparam int CW    = $clog2(LATENCY + 1);
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                rd_state    [NUM_CHANNELS];
    state_t                rd_state_nx [NUM_CHANNELS];
    state_t                wr_state    [NUM_CHANNELS];
    state_t                wr_state_nx [NUM_CHANNELS];
    logic [CW-1:0]         rd_cnt      [NUM_CHANNELS];
    logic [CW-1:0]         rd_cnt_nx   [NUM_CHANNELS];
    logic [CW-1:0]         wr_cnt      [NUM_CHANNELS];
    logic [CW-1:0]         wr_cnt_nx   [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]  rd_addr     [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]  wr_addr     [NUM_CHANNELS];
    logic [DATA_BITS-1:0]  wr_dat      [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] rd_acc, rd_done, wr_acc, wr_done;
    logic [DATA_BITS-1:0]  store       [DEPTH];

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_acc[c]  = rd_state[c] == IDLE && bus.mem_read_valid[c];
            wr_acc[c]  = wr_state[c] == IDLE && bus.mem_write_valid[c];
            rd_done[c] = rd_state[c] == BUSY && rd_cnt[c] == '0;
            wr_done[c] = wr_state[c] == BUSY && wr_cnt[c] == '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rd_state[c] <= IDLE;
                wr_state[c] <= IDLE;
                rd_cnt[c]   <= '0;
                wr_cnt[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rd_state[c] <= rd_state_nx[c];
                wr_state[c] <= wr_state_nx[c];
                rd_cnt[c]   <= rd_cnt_nx[c];
                wr_cnt[c]   <= wr_cnt_nx[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            rd_state_nx[c] = rd_acc[c] ? BUSY : rd_done[c] ? IDLE : rd_state[c];
            wr_state_nx[c] = wr_acc[c] ? BUSY : wr_done[c] ? IDLE : wr_state[c];
            rd_cnt_nx[c]   = rd_acc[c] ? CW'(LATENCY - 1) :
                             (rd_state[c] == BUSY && rd_cnt[c] != '0) ? rd_cnt[c] - 1'b1 : rd_cnt[c];
            wr_cnt_nx[c]   = wr_acc[c] ? CW'(LATENCY - 1) :
                             (wr_state[c] == BUSY && wr_cnt[c] != '0) ? wr_cnt[c] - 1'b1 : wr_cnt[c];
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            bus.mem_read_ready[c]  = rd_state[c] == IDLE;
            bus.mem_write_ready[c] = wr_state[c] == IDLE;
        end
    end

    // Reads sample the store before this edge's writes land, so a same-edge
    // read/write to one address returns the old word. Writes are applied in
    // ascending channel order, so the highest-index channel wins a collision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                rd_addr[c] <= '0;
                wr_addr[c] <= '0;
                wr_dat[c]  <= '0;
            end
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
            bus.mem_read_data <= '0;
        end else begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (rd_acc[c]) rd_addr[c] <= bus.mem_read_address[c];
                if (wr_acc[c]) begin
                    wr_addr[c] <= bus.mem_write_address[c];
                    wr_dat[c]  <= bus.mem_write_data[c];
                end
                if (rd_done[c]) bus.mem_read_data[c] <= store[rd_addr[c]];
            end
            for (int c = 0; c < NUM_CHANNELS; c++)
                if (wr_done[c]) store[wr_addr[c]] <= wr_dat[c];
        end
    end

`ifdef MEM_RESP_PERF_EN
    logic [16:0] rd_sum, wr_sum;

    assign rd_sum = {1'b0, perf_read_count} + 17'($countones(rd_done));
    assign wr_sum = {1'b0, perf_write_count} + 17'($countones(wr_done));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_read_count  <= '0;
            perf_write_count <= '0;
        end else begin
            perf_read_count  <= rd_sum[16] ? 16'hFFFF : rd_sum[15:0];
            perf_write_count <= wr_sum[16] ? 16'hFFFF : wr_sum[15:0];
        end
    end
`endif
endmodule

// File: tb/tb_mem_channel_responder.sv
// tb_mem_channel_responder: directed self-checking bench for mem_channel_responder
module tb_mem_channel_responder;
    localparam int AB = 8;
    localparam int DB = 8;
    localparam int NC = 4;
    localparam int L  = 2;

    logic clk = 0;
    logic reset = 0;
    int   errors = 0;
    int   checks = 0;
    logic [7:0] d;

    always #5 clk = ~clk;

    mem_channel_responder_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC)) bus ();

`ifdef MEM_RESP_PERF_EN
    logic [15:0] perf_read_count, perf_write_count;
`endif

    mem_channel_responder #(.ADDR_BITS(AB), .DATA_BITS(DB), .NUM_CHANNELS(NC), .LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef MEM_RESP_PERF_EN
        ,
        .perf_read_count  (perf_read_count),
        .perf_write_count (perf_write_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int ch, input logic [7:0] a, output logic [7:0] q);
        bus.mem_read_valid[ch]   = 1'b1;
        bus.mem_read_address[ch] = a;
        tick();
        bus.mem_read_valid[ch] = 1'b0;
        repeat (L) tick();
        q = bus.mem_read_data[ch];
    endtask

`ifdef MEM_RESP_PERF_EN
    task automatic round(input logic [NC-1:0] rm, input logic [NC-1:0] wm);
        bus.mem_read_valid  = rm;
        bus.mem_write_valid = wm;
        tick();
        bus.mem_read_valid  = '0;
        bus.mem_write_valid = '0;
        repeat (L) tick();
    endtask
`endif

    initial begin
        bus.mem_read_valid    = '0;
        bus.mem_read_address  = '0;
        bus.mem_write_valid   = '0;
        bus.mem_write_address = '0;
        bus.mem_write_data    = '0;
        repeat (2) tick();
        check("rst_rd_ready", 32'(bus.mem_read_ready), 32'hF);
        check("rst_wr_ready", 32'(bus.mem_write_ready), 32'hF);
        check("rst_rd_data", 32'(bus.mem_read_data), 32'h0);
        reset = 1'b1;
        tick();

        bus.mem_write_valid[0]   = 1'b1;
        bus.mem_write_address[0] = 8'h10;
        bus.mem_write_data[0]    = 8'hA5;
        tick();
        bus.mem_write_valid[0] = 1'b0;
        check("wr_ready_n1", 32'(bus.mem_write_ready[0]), 32'h0);
        tick();
        check("wr_ready_n2", 32'(bus.mem_write_ready[0]), 32'h0);
        tick();
        check("wr_ready_done", 32'(bus.mem_write_ready[0]), 32'h1);

        bus.mem_read_valid[1]   = 1'b1;
        bus.mem_read_address[1] = 8'h10;
        tick();
        bus.mem_read_valid[1] = 1'b0;
        check("rd_ready_busy", 32'(bus.mem_read_ready[1]), 32'h0);
        tick();
        check("rd_data_hold", 32'(bus.mem_read_data[1]), 32'h0);
        tick();
        check("rd_data_a5", 32'(bus.mem_read_data[1]), 32'hA5);

        bus.mem_write_valid      = 4'b1001;
        bus.mem_write_address[0] = 8'h20;
        bus.mem_write_data[0]    = 8'h11;
        bus.mem_write_address[3] = 8'h20;
        bus.mem_write_data[3]    = 8'h33;
        tick();
        bus.mem_write_valid = '0;
        repeat (L) tick();
        rd(2, 8'h20, d);
        check("collision_hi_wins", 32'(d), 32'h33);

        bus.mem_read_valid[0]    = 1'b1;
        bus.mem_read_address[0]  = 8'h30;
        bus.mem_write_valid[2]   = 1'b1;
        bus.mem_write_address[2] = 8'h30;
        bus.mem_write_data[2]    = 8'h7E;
        tick();
        bus.mem_read_valid[0]  = 1'b0;
        bus.mem_write_valid[2] = 1'b0;
        check("race_both_busy", 32'({bus.mem_read_ready[0], bus.mem_write_ready[2]}), 32'h0);
        repeat (L) tick();
        check("race_old_data", 32'(bus.mem_read_data[0]), 32'h00);
        rd(0, 8'h30, d);
        check("race_new_data", 32'(d), 32'h7E);

        bus.mem_write_valid[1]   = 1'b1;
        bus.mem_write_address[1] = 8'h40;
        bus.mem_write_data[1]    = 8'hFF;
        tick();
        bus.mem_write_valid[1] = 1'b0;
        check("midrst_busy", 32'(bus.mem_write_ready[1]), 32'h0);
        reset = 1'b0;
        #1;
        check("midrst_wr_ready", 32'(bus.mem_write_ready), 32'hF);
        check("midrst_rd_ready", 32'(bus.mem_read_ready), 32'hF);
        check("midrst_rd_data", 32'(bus.mem_read_data), 32'h0);
        tick();
        reset = 1'b1;
        tick();
        rd(0, 8'h40, d);
        check("midrst_no_commit", 32'(d), 32'h0);
        rd(3, 8'h10, d);
        check("rst_store_clear", 32'(d), 32'h0);
        rd(3, 8'h20, d);
        check("rst_store_clear2", 32'(d), 32'h0);

`ifdef MEM_RESP_PERF_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("perf_rst", 32'(perf_read_count), 32'h0);
        round(4'hF, 4'hF);
        check("perf_rd_4", 32'(perf_read_count), 32'h4);
        check("perf_wr_4", 32'(perf_write_count), 32'h4);
        repeat (16382) round(4'hF, 4'h0);
        round(4'h3, 4'h0);
        check("perf_fffe", 32'(perf_read_count), 32'hFFFE);
        round(4'hF, 4'h0);
        check("perf_sat", 32'(perf_read_count), 32'hFFFF);
        round(4'hF, 4'h0);
        check("perf_sat_hold", 32'(perf_read_count), 32'hFFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
